// File: rtl/vga_if.sv
// VGA pixel-stream bundle: timing counters, sync and blanking strobes,
// and one 12-bit RGB pixel per clock.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_board.sv
// Overlays a CELLS x CELLS game board on a VGA stream, colouring each cell
// from an external state RAM addressed one clock ahead of the colour stage.
module draw_board #(
    parameter int          BOARD_X     = 100,
    parameter int          BOARD_Y     = 50,
    parameter int          CELL_SIZE   = 32,
    parameter int          CELLS       = 8,
    parameter logic [11:0] GRID_COLOR  = 12'h000,
    parameter logic [11:0] COVER_COLOR = 12'h888,
    parameter logic [11:0] OPEN_COLOR  = 12'hCCC,
    parameter logic [11:0] FLAG_COLOR  = 12'hF00,
    parameter logic [11:0] MINE_COLOR  = 12'h222,
    parameter int          HCOUNT_MAX  = 1055,
    localparam int         AW          = $clog2(CELLS * CELLS)
) (
    input  logic          clk,
    input  logic          rst,
    vga_if.in             in,
    vga_if.out            out,
    output logic [AW-1:0] cell_addr,
    input  logic [2:0]    cell_state
);

    localparam int SW   = $clog2(CELL_SIZE);
    localparam int CW   = $clog2(CELLS + 1);
    localparam int SPAN = CELLS * CELL_SIZE;

    localparam logic [10:0]   X0       = 11'(BOARD_X);
    localparam logic [10:0]   X1       = 11'(BOARD_X + SPAN);
    localparam logic [10:0]   Y0       = 11'(BOARD_Y);
    localparam logic [10:0]   Y1       = 11'(BOARD_Y + SPAN);
    localparam logic [10:0]   Y_PRE    = 11'(BOARD_Y - 1);
    localparam logic [10:0]   H_MAX    = 11'(HCOUNT_MAX);
    localparam logic [SW-1:0] SUB_LAST = SW'(CELL_SIZE - 1);
    localparam logic [CW-1:0] IDX_END  = CW'(CELLS);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } px_t;

    logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [SW-1:0] hsub_c;
    logic [CW-1:0] col_c;
    logic [AW-1:0] cell_addr_q, cell_addr_d;
    px_t           s1_q, s1_d, out_q, out_d;
    logic          grid_q, grid_d, inb_q, inb_d;

    // Horizontal position of the current input pixel; clears on the left edge.
    always_comb begin
        hsub_c = (in.hcount == X0) ? '0 : hsub_q;
        col_c  = (in.hcount == X0) ? '0 : col_q;
        hsub_d = hsub_c;
        col_d  = col_c;
        if (col_c != IDX_END) begin
            if (hsub_c == SUB_LAST) begin
                hsub_d = '0;
                col_d  = col_c + 1'b1;
            end else begin
                hsub_d = hsub_c + 1'b1;
            end
        end
    end

    // Vertical position advances at end of line and parks on the bottom edge.
    always_comb begin
        vsub_d = vsub_q;
        row_d  = row_q;
        if (in.hcount == H_MAX) begin
            if (in.vcount == Y_PRE) begin
                vsub_d = '0;
                row_d  = '0;
            end else if (row_q != IDX_END) begin
                if (vsub_q == SUB_LAST) begin
                    vsub_d = '0;
                    row_d  = row_q + 1'b1;
                end else begin
                    vsub_d = vsub_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        s1_d        = '{in.hcount, in.vcount, in.hsync, in.vsync,
                        in.hblnk, in.vblnk, in.rgb};
        inb_d       = (in.hcount >= X0) && (in.hcount <= X1) &&
                      (in.vcount >= Y0) && (in.vcount <= Y1);
        grid_d      = (hsub_c == '0) || (vsub_q == '0) ||
                      (col_c == IDX_END) || (row_q == IDX_END);
        cell_addr_d = cell_addr_q;
        if (inb_d && (col_c != IDX_END) && (row_q != IDX_END)) begin
            cell_addr_d = AW'(int'(row_q) * CELLS + int'(col_c));
        end
    end

    always_comb begin
        out_d = s1_q;
        if (s1_q.hblnk || s1_q.vblnk) begin
            out_d.rgb = 12'h000;
        end else if (!inb_q) begin
            out_d.rgb = s1_q.rgb;
        end else if (grid_q) begin
            out_d.rgb = GRID_COLOR;
        end else begin
            unique case (cell_state)
                3'd0:    out_d.rgb = COVER_COLOR;
                3'd2:    out_d.rgb = FLAG_COLOR;
                3'd3:    out_d.rgb = MINE_COLOR;
                default: out_d.rgb = OPEN_COLOR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsub_q      <= '0;
            col_q       <= '0;
            vsub_q      <= '0;
            row_q       <= '0;
            cell_addr_q <= '0;
            s1_q        <= '0;
            grid_q      <= 1'b0;
            inb_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            hsub_q      <= hsub_d;
            col_q       <= col_d;
            vsub_q      <= vsub_d;
            row_q       <= row_d;
            cell_addr_q <= cell_addr_d;
            s1_q        <= s1_d;
            grid_q      <= grid_d;
            inb_q       <= inb_d;
            out_q       <= out_d;
        end
    end

    assign cell_addr  = cell_addr_q;
    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_board.sv
// Scoreboard bench for draw_board: random frames checked against a
// division-based board model, plus directed edge, blanking and reset cases.
module tb_draw_board;

    localparam int BX   = 100;
    localparam int BY   = 50;
    localparam int CS   = 32;
    localparam int N    = 8;
    localparam int HMAX = 400;
    localparam int AW   = 6;

    localparam logic [11:0] GRID  = 12'h000;
    localparam logic [11:0] COVER = 12'h888;
    localparam logic [11:0] OPEN  = 12'hCCC;
    localparam logic [11:0] FLAG  = 12'hF00;
    localparam logic [11:0] MINE  = 12'h222;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cell_addr;
    logic [2:0]    cell_state;
    logic [2:0]    mem [0:N*N-1];

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;

    assign cell_state = mem[cell_addr];

    draw_board #(
        .HCOUNT_MAX(HMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (vin),
        .out       (vout),
        .cell_addr (cell_addr),
        .cell_state(cell_state)
    );

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic       drv_valid = 1'b0;
    logic [1:0] sv;

    // Marks which output cycles carry a pixel with a queued expectation.
    always @(posedge clk or posedge rst) begin
        if (rst) sv <= 2'b00;
        else     sv <= {sv[0], drv_valid};
    end

    function automatic logic [11:0] ref_rgb(input int h, input int v,
                                            input bit hb, input bit vb,
                                            input logic [11:0] rgb);
        int col, row, hs, vs;
        if (hb || vb) return 12'h000;
        if (h < BX || h > BX + N*CS || v < BY || v > BY + N*CS) return rgb;
        col = (h - BX) / CS;
        hs  = (h - BX) % CS;
        row = (v - BY) / CS;
        vs  = (v - BY) % CS;
        if (hs == 0 || vs == 0 || col == N || row == N) return GRID;
        case (mem[row*N + col])
            3'd0:    return COVER;
            3'd2:    return FLAG;
            3'd3:    return MINE;
            default: return OPEN;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t a, e;
        if (!rst && sv[1]) begin
            a = '{vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                  vout.hblnk, vout.vblnk, vout.rgb};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL underflow: output %h with no expectation", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL pixel h=%0d v=%0d: got rgb=%h h=%0d v=%0d syn=%b%b blk=%b%b want rgb=%h h=%0d v=%0d syn=%b%b blk=%b%b",
                             e.hcount, e.vcount, a.rgb, a.hcount, a.vcount,
                             a.hsync, a.vsync, a.hblnk, a.vblnk,
                             e.rgb, e.hcount, e.vcount,
                             e.hsync, e.vsync, e.hblnk, e.vblnk);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic px(input int h, input int v, input bit hb, input bit vb,
                      input logic [11:0] rgb, input bit check);
        exp_t e;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = 1'($urandom_range(1));
        vin.vsync  = 1'($urandom_range(1));
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        if (check) begin
            e = '{vin.hcount, vin.vcount, vin.hsync, vin.vsync,
                  hb, vb, ref_rgb(h, v, hb, vb, rgb)};
            q.push_back(e);
        end
        drv_valid = check;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input int v, input int hs, input int he,
                        input bit rnd, input logic [11:0] rgb);
        bit vb;
        vb = rnd && ($urandom_range(31) == 0);
        for (int h = hs; h <= he; h++) begin
            px(h, v, rnd && ($urandom_range(15) == 0), vb,
               rnd ? 12'($urandom) : rgb, 1'b1);
        end
        px(HMAX, v, 1'b1, vb, rnd ? 12'($urandom) : rgb, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = '0;
        for (int a = 0; a < N*N; a++) mem[a] = 3'(a % 4);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(vout.rgb), 0);
        chk("rst_hcount", 32'(vout.hcount), 0);
        chk("rst_vcount", 32'(vout.vcount), 0);
        chk("rst_flags", 32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 0);
        chk("rst_addr", 32'(cell_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Top-left corner: grid colour, address 0 one clock later.
        px(100, 50, 1'b0, 1'b0, 12'h5A5, 1'b1);
        chk("corner_addr", 32'(cell_addr), 0);
        idle(2);

        // Cell (1,1) interior holding a flag.
        mem[9] = 3'd2;
        for (int v = 49; v <= 82; v++) line(v, 1, 0, 1'b0, 12'h123);
        for (int h = 100; h <= 133; h++) px(h, 83, 1'b0, 1'b0, 12'h321, 1'b1);
        chk("flag_addr", 32'(cell_addr), 9);
        idle(2);
        mem[9] = 3'd1;

        // Left/right boundary pass-through and right-edge grid.
        line(49, 1, 0, 1'b0, 12'h0A5);
        line(50, 99, 99, 1'b0, 12'h0A5);
        for (int v = 51; v <= 59; v++) line(v, 1, 0, 1'b0, 12'h0A5);
        line(60, 100, 357, 1'b0, 12'h0A5);

        // Horizontal blanking inside the board.
        for (int h = 100; h <= 140; h++)
            px(h, 61, (h >= 110 && h <= 115), 1'b0, 12'h777, 1'b1);
        idle(2);

        // Random full-board sweep.
        for (int v = 49; v <= 307; v++) line(v, 99, 357, 1'b1, 12'h000);
        idle(2);

        // Reset asserted mid-line must clear outputs without a clock edge.
        for (int h = 150; h <= 200; h++) px(h, 120, 1'b0, 1'b0, 12'hABC, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rgb", 32'(vout.rgb), 0);
        chk("async_hcount", 32'(vout.hcount), 0);
        chk("async_vcount", 32'(vout.vcount), 0);
        chk("async_flags", 32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 0);
        chk("async_addr", 32'(cell_addr), 0);
        q.delete();
        drv_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 49; v <= 85; v++) line(v, 99, 357, 1'b1, 12'h000);
        idle(4);
        chk("queue_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_board.md
DRAW_BOARD -- requirements
Module: draw_board

Interface
REQ-001 Parameter BOARD_X, default 100: horizontal pixel of the board's left edge.
REQ-002 Parameter BOARD_Y, default 50: vertical pixel of the board's top edge.
REQ-003 Parameter CELL_SIZE, default 32: cell pitch in pixels, in both axes; legal range 2..64.
REQ-004 Parameter CELLS, default 8: cells per row and per column; legal range 2..16.
REQ-005 Parameters GRID_COLOR 12'h000, COVER_COLOR 12'h888, OPEN_COLOR 12'hCCC, FLAG_COLOR 12'hF00, MINE_COLOR 12'h222: 12-bit RGB colours.
REQ-006 Localparam AW = $clog2(CELLS*CELLS): cell address width.
REQ-007 clk  input  1  system pixel clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 in  vga_if.in  bundle  upstream timing and background: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
REQ-010 out  vga_if.out  bundle  downstream timing with the board drawn in; feeds the frame-buffered output stage.
REQ-011 cell_addr  output  AW  index into the external board-state RAM: row*CELLS + col.
REQ-012 cell_state  input  3  RAM read data, valid exactly 1 clk after cell_addr is presented.

Function
REQ-013 Board area: H = BOARD_X..BOARD_X+CELLS*CELL_SIZE inclusive; V = BOARD_Y..BOARD_Y+CELLS*CELL_SIZE inclusive.
REQ-014 For an in-board pixel (h,v): col = (h-BOARD_X)/CELL_SIZE, hsub = (h-BOARD_X)%CELL_SIZE. row and vsub are defined the same way from v and BOARD_Y.
REQ-015 col, hsub, row and vsub are derived from counters: no divide or modulo operators in RTL.
REQ-016 Horizontal counters clear when in.hcount == BOARD_X. hsub then increments each clk; on reaching CELL_SIZE-1 it wraps to 0 and col increments.
REQ-017 Vertical counters clear at in.hcount == HCOUNT_MAX with in.vcount == BOARD_Y-1. They advance once per line, at in.hcount == HCOUNT_MAX, with the same wrap rule.
REQ-018 Pipeline stage 1 (1 clk) registers the timing signals, in.rgb, the grid and in-board flags, and cell_addr.
REQ-019 Pipeline stage 2 (1 clk) registers the out fields; cell_state is sampled in this stage.
REQ-020 Total latency from in to out is 2 clk for every field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
REQ-021 Colour priority, highest first:
  1. hblnk or vblnk -> 12'h000.
  2. Outside the board area -> in.rgb unchanged.
  3. Grid pixel (hsub==0, vsub==0, h==right edge or v==bottom edge) -> GRID_COLOR.
  4. Otherwise by cell_state: 0 -> COVER_COLOR, 2 -> FLAG_COLOR, 3 -> MINE_COLOR, 1 and 4..7 -> OPEN_COLOR.
REQ-022 col==CELLS occurs only on the right-edge column. In that case cell_addr holds its previous value and the pixel is a grid pixel; the same holds for row==CELLS on the bottom edge.
REQ-023 cell_addr is held constant outside the board area.

Reset
REQ-024 While rst is high, every out field, cell_addr and all counters are 0, and all pipeline registers are cleared.
REQ-025 Reset takes effect immediately and asynchronously, independent of clk.
REQ-026 After rst deasserts mid-frame:
  - Pass-through and blanking are correct from the 3rd clk onward.
  - Board colours are correct from the first line with vcount == BOARD_Y onward.

Verification
REQ-027 Defaults, in=(hcount 100, vcount 50, unblanked) -> out.rgb=GRID_COLOR 2 clk later; cell_addr=0 1 clk after input.
REQ-028 in=(133,83), cell_state=2 on the following clk -> cell_addr=9, then out.rgb=12'hF00 with out.hcount=133 and out.vcount=83.
REQ-029 in=(99,50), in.rgb=12'h0A5 -> out.rgb=12'h0A5; in=(356,60) -> GRID_COLOR; in=(357,60) -> pass-through.
REQ-030 Blanking: in.hblnk=1 at an in-board pixel -> out.rgb=12'h000, with sync fields delayed exactly 2 clk.
REQ-031 Full-frame sweep against a division-based model, cell_state = addr%4: zero pixel mismatches, including the pixels at 131/132 and 355/356.
REQ-032 Assert rst mid-line at (200,120) -> all outputs 0 within the same clk. After release, the next frame matches the reference model.
